// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for a five-stage in-order core. It produces the
// load enables and the bubble (clear) strobes for the PC and the IF/ID, ID/EX
// and EX/MEM pipeline registers. It also reports when a multi-cycle operation
// or a fetch drain is in progress, and it counts the cycles in which the PC
// was held.
//
// Parameters
//   MD_CYCLES    : number of cycles a mul/div op occupies EX (legal 2..15)
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   id_rs1/2     : source register indices of the instruction in ID
//   id_use_rs1/2 : the ID instruction actually reads rs1 / rs2
//   ex_rd        : destination register of the instruction in EX
//   ex_mem_read  : the EX instruction is a load
//   ex_redirect  : a branch or jump resolved in EX and changes the PC
//   ex_md_start  : one-cycle pulse in the first EX cycle of a mul/div op
//   imem_ready   : fetch data for the current PC is valid this cycle
//   dmem_stall   : the MEM-stage data access is not complete
//   *_en         : load enables for the PC and the pipeline registers
//   *_clear      : synchronous bubble insertion into the pipeline registers
//   busy         : state is not RUN
//   stall_count  : cycles with pc_en low since reset (wraps modulo 2^32)
//
// The outputs are combinational from the state and the inputs. They are
// forced low while rst_n is low.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_redirect,
    input  logic        ex_md_start,
    input  logic        imem_ready,
    input  logic        dmem_stall,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        if_id_clear,
    output logic        id_ex_clear,
    output logic        ex_mem_clear,
    output logic        busy,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic [3:0] MD_LOAD = 4'(MD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  md_cnt_q, md_cnt_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic        load_use_s;

    // Load-use hazard: the ID instruction reads the register that the load in EX writes. x0 is excluded.
    always_comb begin
        load_use_s = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // Next-state and output decode. The branches are tested in priority order, and the first match wins.
    always_comb begin
        state_d      = state_q;
        md_cnt_d     = md_cnt_q;
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_clear  = 1'b0;
        id_ex_clear  = 1'b0;
        ex_mem_clear = 1'b0;
        busy         = (state_q != RUN);

        if (!rst_n) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            busy      = 1'b0;
        end else if (dmem_stall) begin
            // Whole pipe frozen; state and counter hold.
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end else begin
            case (state_q)
                MD_BUSY: begin
                    // Front end held; bubbles flow into MEM while the op occupies EX.
                    pc_en        = 1'b0;
                    if_id_en     = 1'b0;
                    id_ex_en     = 1'b0;
                    ex_mem_clear = 1'b1;
                    md_cnt_d     = md_cnt_q - 4'd1;
                    if (md_cnt_q == 4'd1) begin
                        state_d = RUN;
                    end else begin
                        state_d = MD_BUSY;
                    end
                end
                DRAIN: begin
                    // The wrong-path fetch is still outstanding. Keep the PC and discard what arrives.
                    pc_en       = 1'b0;
                    if_id_clear = 1'b1;
                    if (imem_ready) begin
                        state_d = RUN;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                RUN: begin
                    if (ex_md_start) begin
                        // The start cycle counts as the first of MD_CYCLES stall cycles.
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_clear = 1'b1;
                        md_cnt_d     = MD_LOAD;
                        state_d      = MD_BUSY;
                    end else if (ex_redirect) begin
                        // The redirect overrides any load-use. The PC loads the target.
                        if_id_clear = 1'b1;
                        id_ex_clear = 1'b1;
                        if (!imem_ready) begin
                            state_d = DRAIN;
                        end else begin
                            state_d = RUN;
                        end
                    end else if (load_use_s) begin
                        // Hold PC and ID, and put one bubble into EX. The IF/ID clear stays low,
                        // even on an imem miss, so that the ID instruction is kept.
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_clear = 1'b1;
                    end else if (!imem_ready) begin
                        pc_en       = 1'b0;
                        if_id_clear = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d  = RUN;
                    md_cnt_d = 4'd0;
                end
            endcase
        end
    end

    // Stall counter next value. It wraps naturally at 2^32.
    always_comb begin
        if (!pc_en) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State, mul/div counter and stall counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            md_cnt_q      <= 4'd0;
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MD_CYCLES, 4, number of cycles a mul/div op occupies EX; the legal range is 2..15.
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  the reset, which is asynchronous and active-low.
REQ-004 id_rs1, id_rs2  input  5 each  the source register indices of the instruction in ID.
REQ-005 id_use_rs1, id_use_rs2  input  1 each  indicate that the ID instruction actually reads rs1 or rs2.
REQ-006 ex_rd  input  5  the destination register of the instruction in EX.
REQ-007 ex_mem_read  input  1  indicates that the EX instruction is a load.
REQ-008 ex_redirect  input  1  indicates that a branch or jump resolved in EX and changes the PC.
REQ-009 ex_md_start  input  1  one-cycle pulse in the first EX cycle of a mul/div op.
REQ-010 imem_ready  input  1  the fetch data for the current PC is valid this cycle.
REQ-011 dmem_stall  input  1  the MEM-stage data access is not complete.
REQ-012 pc_en, if_id_en, id_ex_en, ex_mem_en  output  1 each  the load enables for the PC and the pipeline registers.
REQ-013 if_id_clear, id_ex_clear, ex_mem_clear  output  1 each  synchronous bubble insertion into the named pipeline registers.
REQ-014 busy  output  1  high whenever the state is not RUN.
REQ-015 stall_count  output  32  the number of cycles in which pc_en was 0 since reset; wraps modulo 2^32.

Function
REQ-016 The block SHALL be an FSM with three states: RUN, MD_BUSY and DRAIN.
REQ-017 The block SHALL contain a 4-bit down-counter md_cnt.
REQ-018 Outputs SHALL be combinational from the state and inputs, evaluated in the priority order REQ-019 to REQ-025 (first match wins); the default is all enables 1 and all clears 0.
REQ-019 When dmem_stall=1, in any state: all enables 0, all clears 0, state and md_cnt frozen.
REQ-020 In MD_BUSY: pc_en, if_id_en and id_ex_en 0, ex_mem_en 1, ex_mem_clear 1.
  - md_cnt decrements each cycle.
  - At md_cnt==1 the next state is RUN.
  - ex_redirect and ex_md_start are ignored in MD_BUSY.
REQ-021 On ex_md_start in RUN: the same outputs as MD_BUSY; md_cnt <= MD_CYCLES-1; next state MD_BUSY.
  - The total stall is MD_CYCLES cycles.
REQ-022 On ex_redirect in RUN:
  - pc_en 1, if_id_clear 1, id_ex_clear 1.
  - If imem_ready=0 the next state is DRAIN; otherwise it stays RUN.
REQ-023 In DRAIN: pc_en 0, if_id_clear 1.
  - When imem_ready=1 the next state is RUN; the in-flight wrong-path fetch is discarded.
REQ-024 Load-use in RUN: ex_mem_read=1, ex_rd!=0, and (id_use_rs1 with id_rs1==ex_rd, or id_use_rs2 with id_rs2==ex_rd).
  - Outputs: pc_en 0, if_id_en 0, id_ex_clear 1.
  - This holds for exactly one cycle per hazard.
REQ-025 imem_ready=0 in RUN: pc_en 0, if_id_clear 1.
  - Exception: if the load-use condition also holds, if_id_en 0 and if_id_clear 0, so the ID instruction is kept.
REQ-026 ex_redirect and a load-use in the same cycle: the redirect wins, with no load-use bubble.
REQ-027 stall_count SHALL increment on every clock edge where rst_n=1 and pc_en=0; 0xFFFFFFFF wraps to 0.
REQ-028 A clear and an enable on the same register in the same cycle: the clear wins in the pipeline register.
  - The block SHALL never assert if_id_en=0 together with if_id_clear=1.

Reset
REQ-029 While rst_n=0, regardless of clk:
  - state=RUN, md_cnt=0, stall_count=0.
  - All enables, all clears and busy are 0.
REQ-030 Reset asserted mid-MD_BUSY or mid-DRAIN SHALL abort immediately; after release the block is in RUN with default outputs.
REQ-031 Deassertion SHALL take effect at the first rising clk edge after rst_n rises.

Verification
REQ-032 Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1, imem_ready=1 -> pc_en=0, if_id_en=0, id_ex_clear=1 for one cycle; stall_count +1.
REQ-033 Load-use with ex_rd=0 and id_rs1=0 -> no stall; all enables 1.
REQ-034 MD_CYCLES=4, ex_md_start pulse -> pc_en=0 for 4 consecutive cycles; busy=1 for 3 cycles; RUN on the 5th cycle.
  - With dmem_stall=1 for 2 cycles in the middle -> 6 stall cycles.
REQ-035 ex_redirect with imem_ready=0, then imem_ready=1 after 3 cycles:
  - Redirect cycle: pc_en=1.
  - Then DRAIN for 3 cycles with if_id_clear=1 and pc_en=0.
  - Then RUN.
REQ-036 ex_redirect and load-use simultaneously -> if_id_clear=1, id_ex_clear=1, pc_en=1; no stall counted.
REQ-037 rst_n pulled low during MD_BUSY (md_cnt=2):
  - All outputs 0 asynchronously and stall_count=0.
  - After release the block is in RUN with all enables 1.
